// File: rtl/preg_free_list.sv
// Physical-register free list: FWFT circular FIFO of free tags plus a per-tag
// "is free" bitmap used to reject double releases.
module preg_free_list #(
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned NUM_AREGS = 32,
  localparam int unsigned TAG_W    = $clog2(NUM_PREGS),
  localparam int unsigned DEPTH    = NUM_PREGS - NUM_AREGS,
  localparam int unsigned PTR_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             alloc_req,
  output logic             alloc_valid,
  output logic [TAG_W-1:0] alloc_preg,
  output logic             stall,
  input  logic             rel_valid,
  input  logic [TAG_W-1:0] rel_preg,
  output logic [CNT_W-1:0] free_count,
  output logic             err_double,
  output logic             err_overflow
);

  logic [TAG_W-1:0]     fifo_q [DEPTH];
  logic [TAG_W-1:0]     fifo_d [DEPTH];
  logic [NUM_PREGS-1:0] free_q, free_d;
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 err_double_q, err_double_d;
  logic                 err_overflow_q, err_overflow_d;

  logic pop, push, rel_qual, rel_is_free, room;

  // Head of the FIFO is presented directly (first-word-fall-through).
  always_comb begin
    alloc_valid  = (count_q != '0);
    stall        = ~alloc_valid;
    alloc_preg   = fifo_q[head_q];
    free_count   = count_q;
    err_double   = err_double_q;
    err_overflow = err_overflow_q;
  end

  // Pop/push qualification and next-state; pointers wrap because DEPTH is a power of two.
  always_comb begin
    fifo_d         = fifo_q;
    free_d         = free_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    err_double_d   = err_double_q;
    err_overflow_d = err_overflow_q;

    pop         = alloc_req && (count_q != '0);
    rel_qual    = rel_valid && (rel_preg != '0);
    rel_is_free = free_q[rel_preg];
    // A same-cycle pop frees a slot, so a full list can still accept the release.
    room        = (count_q != CNT_W'(DEPTH)) || pop;
    push        = rel_qual && !rel_is_free && room;

    if (rel_qual && rel_is_free) begin
      err_double_d = 1'b1;
    end
    if (rel_qual && !rel_is_free && !room) begin
      err_overflow_d = 1'b1;
    end

    if (pop) begin
      free_d[fifo_q[head_q]] = 1'b0;
      head_d                 = head_q + PTR_W'(1);
    end
    if (push) begin
      fifo_d[tail_q]   = rel_preg;
      free_d[rel_preg] = 1'b1;
      tail_d           = tail_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // State registers; reset loads the unmapped tags NUM_AREGS..NUM_PREGS-1 as free.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= TAG_W'(NUM_AREGS + i);
      end
      for (int i = 0; i < NUM_PREGS; i++) begin
        free_q[i] <= (i >= NUM_AREGS);
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= CNT_W'(DEPTH);
      err_double_q   <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      fifo_q         <= fifo_d;
      free_q         <= free_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      err_double_q   <= err_double_d;
      err_overflow_q <= err_overflow_d;
    end
  end

endmodule
